// File: rtl/trace_pkg.sv
// trace_pkg: character constants, arbiter state type and the modulo-N pointer increment.
package trace_pkg;
   localparam logic [7:0] CH_CARET = 8'h5E;
   localparam logic [7:0] CH_HASH  = 8'h23;
   typedef enum logic {IDLE, PASS} state_t;
   function automatic logic [2:0] wrap_inc(input logic [2:0] v, input int n);
      return (int'(v) + 1 >= n) ? 3'd0 : v + 3'd1;
   endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: first set bit of cand at or after ptr, wrapping modulo N_SRC.
module rr_picker
   import trace_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int GW    = 2
) (
   input  logic [N_SRC-1:0] cand,
   input  logic [GW-1:0]    ptr,
   output logic             found,
   output logic [GW-1:0]    idx
);
   logic [GW-1:0] j;
   always_comb begin
      found = 1'b0;
      idx   = '0;
      j     = '0;
      // Scan backwards so the candidate closest to ptr is the last one written.
      for (int k = N_SRC - 1; k >= 0; k--) begin
         j = GW'((int'(ptr) + k) % N_SRC);
         if (cand[j]) begin
            found = 1'b1;
            idx   = j;
         end
      end
   end
endmodule

// File: rtl/trace_arbiter.sv
// trace_arbiter: round-robin arbiter granting the checker character channel one whole
// ^...# record at a time, draining strays in IDLE and aborting stalled records.
module trace_arbiter
   import trace_pkg::*;
#(
   parameter int  N_SRC   = 4,
   parameter int  TIMEOUT = 64,
   localparam int GW      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_SRC-1:0]   req_valid,
   input  logic [8*N_SRC-1:0] req_char,
   output logic [N_SRC-1:0]   req_ready,
   output logic               out_valid,
   output logic [7:0]         out_char,
   input  logic               out_ready,
   output logic               busy,
   output logic [GW-1:0]      grant_id,
   output logic               record_done,
   output logic               abort
);
   localparam int            CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   state_t           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [7:0]       out_char_q, out_char_d;
   logic [GW-1:0]    grant_id_q, grant_id_d;
   logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]    idle_cnt_q, idle_cnt_d;
   logic             record_done_q, record_done_d;
   logic             abort_q, abort_d;
   logic [N_SRC-1:0] cand, rdy;
   logic [GW-1:0]    win, rr_next;
   logic [7:0]       g_char;
   logic             found, slot_free, acc;

   rr_picker #(.N_SRC(N_SRC), .GW(GW)) u_picker (
      .cand  (cand),
      .ptr   (rr_ptr_q),
      .found (found),
      .idx   (win)
   );

   assign slot_free = !out_valid_q || out_ready;
   assign g_char    = req_char[{grant_id_q, 3'b000} +: 8];
   assign acc       = (state_q == PASS) && slot_free && req_valid[grant_id_q];
   assign rr_next   = GW'(wrap_inc(3'(grant_id_q), N_SRC));

   always_comb begin
      cand = '0;
      for (int i = 0; i < N_SRC; i++) cand[i] = req_valid[i] && (req_char[8*i +: 8] == CH_CARET);
   end

   always_comb begin
      state_d       = state_q;
      out_valid_d   = out_valid_q && !out_ready;
      out_char_d    = out_char_q;
      grant_id_d    = grant_id_q;
      rr_ptr_d      = rr_ptr_q;
      idle_cnt_d    = idle_cnt_q;
      record_done_d = 1'b0;
      abort_d       = 1'b0;
      rdy           = req_valid & ~cand;
      if (state_q == IDLE) begin
         if (found && slot_free) begin
            rdy[win]    = 1'b1;
            out_valid_d = 1'b1;
            out_char_d  = CH_CARET;
            grant_id_d  = win;
            idle_cnt_d  = '0;
            state_d     = PASS;
         end
      end else begin
         rdy             = '0;
         rdy[grant_id_q] = acc;
         if (acc) begin
            out_valid_d = 1'b1;
            out_char_d  = g_char;
            idle_cnt_d  = '0;
            if (g_char == CH_HASH) begin
               record_done_d = 1'b1;
               rr_ptr_d      = rr_next;
               state_d       = IDLE;
            end
         end else if (!req_valid[grant_id_q]) begin
            // Only source silence counts; back-pressure from the checker never aborts.
            idle_cnt_d = (idle_cnt_q == TMAX) ? idle_cnt_q : idle_cnt_q + CW'(1);
            if (idle_cnt_d == TMAX) begin
               abort_d  = 1'b1;
               rr_ptr_d = rr_next;
               state_d  = IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         out_valid_q   <= 1'b0;
         out_char_q    <= '0;
         grant_id_q    <= '0;
         rr_ptr_q      <= '0;
         idle_cnt_q    <= '0;
         record_done_q <= 1'b0;
         abort_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         out_valid_q   <= out_valid_d;
         out_char_q    <= out_char_d;
         grant_id_q    <= grant_id_d;
         rr_ptr_q      <= rr_ptr_d;
         idle_cnt_q    <= idle_cnt_d;
         record_done_q <= record_done_d;
         abort_q       <= abort_d;
      end
   end

   assign req_ready   = reset ? '0 : rdy;
   assign out_valid   = out_valid_q;
   assign out_char    = out_char_q;
   assign busy        = (state_q == PASS);
   assign grant_id    = grant_id_q;
   assign record_done = record_done_q;
   assign abort       = abort_q;
endmodule

// File: tb/tb_trace_arbiter.sv
// tb_trace_arbiter: per-source character queues drive trace_arbiter; a behavioural model
// predicts every output each cycle, and directed scenarios pin the model with literal results.
module tb_trace_arbiter;
   localparam int N  = 4;
   localparam int TO = 64;

   logic         clk       = 1'b0;
   logic         reset     = 1'b1;
   logic [N-1:0] req_valid = '0;
   logic [8*N-1:0] req_char = '0;
   logic [N-1:0] req_ready;
   logic         out_valid;
   logic [7:0]   out_char;
   logic         out_ready = 1'b1;
   logic         busy, record_done, abort;
   logic [1:0]   grant_id;

   trace_arbiter #(.N_SRC(N), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_char    (req_char),
      .req_ready   (req_ready),
      .out_valid   (out_valid),
      .out_char    (out_char),
      .out_ready   (out_ready),
      .busy        (busy),
      .grant_id    (grant_id),
      .record_done (record_done),
      .abort       (abort)
   );

   always #5 clk = ~clk;

   byte unsigned q[N][$];
   bit           v[N];
   byte unsigned c[N];
   bit           m_busy, m_ov, m_done, m_abort;
   byte unsigned m_oc;
   int           m_gid, m_ptr, m_stall;
   logic [N-1:0] exp_rdy;
   int           acc, cyc, n_chk, n_pass, n_done, n_abort;
   int           t_acc, t_hash, abort_gap, grant_gap, or_mode;
   bit           gap;
   int           grants[$];
   string        got;
   string        r1 = "^12@00003000: $ 3 <= 0000abcd#";

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic chk_s(input string name, input string act, input string exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
   endtask

   task automatic load(input int i, input string s);
      for (int k = 0; k < s.len(); k++) q[i].push_back(s[k]);
   endtask

   function automatic bit q_any();
      for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   // One clock: drive sources, predict, compare at negedge, advance the model at posedge.
   task automatic cycle();
      byte unsigned ch;
      bit slot;
      int win;
      for (int i = 0; i < N; i++) begin
         v[i] = q[i].size() > 0 && (!gap || $urandom_range(0, 3) != 0);
         c[i] = q[i].size() > 0 ? q[i][0] : 8'($urandom_range(0, 255));
         req_valid[i] = v[i];
         req_char[8*i +: 8] = c[i];
      end
      out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? (cyc % 2 == 0) :
                  (or_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
      slot = !m_ov || out_ready;
      exp_rdy = '0;
      win = -1;
      acc = -1;
      if (!reset && !m_busy) begin
         for (int k = 0; k < N; k++)
            if (win < 0 && v[(m_ptr + k) % N] && c[(m_ptr + k) % N] == 8'h5E) win = (m_ptr + k) % N;
         for (int i = 0; i < N; i++) exp_rdy[i] = v[i] && c[i] != 8'h5E;
         if (win >= 0 && slot) begin
            exp_rdy[win] = 1'b1;
            acc = win;
         end
      end else if (!reset && slot && v[m_gid]) begin
         exp_rdy[m_gid] = 1'b1;
         acc = m_gid;
      end
      @(negedge clk);
      chk("out_valid", out_valid, m_ov);
      chk("out_char", out_char, m_oc);
      chk("busy", busy, m_busy);
      chk("grant_id", grant_id, m_gid);
      chk("record_done", record_done, m_done);
      chk("abort", abort, m_abort);
      chk("req_ready", req_ready, exp_rdy);
      @(posedge clk);
      if (reset) begin
         m_busy = 0; m_ov = 0; m_oc = 0; m_gid = 0; m_ptr = 0; m_stall = 0; m_done = 0; m_abort = 0;
      end else begin
         m_done = 0;
         m_abort = 0;
         if (out_ready) m_ov = 0;
         ch = (acc >= 0) ? c[acc] : 8'h00;
         for (int i = 0; i < N; i++) if (exp_rdy[i]) void'(q[i].pop_front());
         if (acc >= 0) begin
            m_ov = 1;
            m_oc = ch;
            got = $sformatf("%s%c", got, ch);
            m_stall = 0;
            if (!m_busy) begin
               m_busy = 1;
               m_gid = acc;
               grants.push_back(acc);
               grant_gap = cyc - t_hash;
            end else if (ch == 8'h23) begin
               m_busy = 0;
               m_done = 1;
               n_done++;
               m_ptr = (m_gid + 1) % N;
               t_hash = cyc;
            end
            t_acc = cyc;
         end else if (m_busy && !v[m_gid]) begin
            m_stall++;
            if (m_stall == TO) begin
               m_busy = 0;
               m_abort = 1;
               n_abort++;
               m_ptr = (m_gid + 1) % N;
               abort_gap = cyc - t_acc;
            end
         end
      end
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      chk("rst_req_ready", req_ready, 0);
      reset = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_char", out_char, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_done", record_done, 0);
      chk("rst_abort", abort, 0);
      got = "";
      n_done = 0;
      n_abort = 0;
      grants.delete();
   endtask

   task automatic drain();
      int b = 0;
      while ((m_busy || m_ov || q_any()) && b < 3000) begin
         cycle();
         b++;
      end
      chk("drain_bound", b < 3000, 1);
   endtask

   task automatic gen(input int i);
      int len = $urandom_range(1, 10);
      if ($urandom_range(0, 3) == 0) q[i].push_back(8'(8'h78 + $urandom_range(0, 2)));
      q[i].push_back(8'h5E);
      for (int k = 0; k < len; k++)
         q[i].push_back(8'(($urandom_range(0, 15) == 0) ? 8'h5E : $urandom_range(97, 122)));
      if ($urandom_range(0, 7) != 0) q[i].push_back(8'h23);
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Single record, source waiting through reset.
      load(0, r1);
      do_reset();
      drain();
      chk_s("s1_stream", got, r1);
      chk("s1_len", got.len(), 30);
      chk("s1_done", n_done, 1);
      chk("s1_grant", grant_id, 0);
      // Simultaneous requests from 0 and 2.
      do_reset();
      load(0, "^ab#");
      load(2, "^cd#");
      drain();
      chk_s("s2_stream", got, "^ab#^cd#");
      chk("s2_ngrants", grants.size(), 2);
      chk("s2_first", grants[0], 0);
      chk("s2_second", grants[1], 2);
      chk("s2_b2b_gap", grant_gap, 1);
      chk("s2_ptr", m_ptr, 3);
      // Strays from source 1 wait while source 0 is granted.
      do_reset();
      load(0, "^pq");
      cycle();
      cycle();
      load(1, "xy^zz#");
      cycle();
      cycle();
      chk("s3_hold", q[1].size(), 6);
      load(0, "r#");
      drain();
      chk_s("s3_stream", got, "^pqr#^zz#");
      chk("s3_done", n_done, 2);
      // Timeout abort, then back-pressure without abort.
      do_reset();
      load(0, "^1@");
      load(3, "^ok#");
      drain();
      chk_s("s4_stream", got, "^1@^ok#");
      chk("s4_aborts", n_abort, 1);
      chk("s4_abort_gap", abort_gap, 64);
      chk("s4_next", grants[1], 3);
      got = "";
      load(1, "^abc#");
      cycle();
      cycle();
      or_mode = 3;
      repeat (100) cycle();
      chk("s4_no_abort", n_abort, 1);
      chk("s4_still_busy", busy, 1);
      or_mode = 0;
      drain();
      chk_s("s4_bp_stream", got, "^abc#");
      // Toggling out_ready.
      do_reset();
      or_mode = 1;
      load(2, "^tgl#");
      drain();
      or_mode = 0;
      chk_s("s5_stream", got, "^tgl#");
      chk("s5_done", n_done, 1);
      // Reset mid-record.
      do_reset();
      load(1, "^abcdef#");
      repeat (3) cycle();
      do_reset();
      chk("s6_retained", q[1].size(), 5);
      load(0, "^00#");
      load(3, "^zz#");
      drain();
      chk_s("s6_stream", got, "^00#^zz#");
      // Random traffic.
      do_reset();
      gap = 1;
      or_mode = 2;
      for (int n = 0; n < 4000; n++) begin
         for (int i = 0; i < N; i++) if (q[i].size() == 0 && $urandom_range(0, 7) == 0) gen(i);
         cycle();
      end
      drain();
      chk("rand_activity", n_done > 20, 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
